// File: rtl/decode_queue_pkg.sv
// Shared encodings for the 6502 fetch-side decoder: addressing modes, instruction
// classes, register destinations, ALU ops and the decoded-bundle layout.
package decode_queue_pkg;

    typedef enum logic [1:0] {S_OP, S_LO, S_HI} state_e;

    typedef enum logic [2:0] {
        AM_IMPL, AM_IMM, AM_ZP, AM_ABS, AM_ZPX, AM_ABSX, AM_REL
    } addr_mode_e;

    typedef enum logic [7:0] {
        I_LDA, I_LDX, I_LDY, I_STA, I_STX, I_STY,
        I_ADC, I_SBC, I_AND, I_ORA, I_EOR,
        I_INC, I_DEC, I_ASL, I_LSR, I_ROL, I_ROR,
        I_BR,  I_JMP, I_INX, I_INY, I_DEX, I_DEY,
        I_TAX, I_TXA, I_TAY, I_TYA, I_TSX, I_TXS, I_NOP
    } instr_type_e;

    typedef enum logic [2:0] {RD_NONE, RD_A, RD_X, RD_Y, RD_MEM, RD_SP} reg_dest_e;

    typedef enum logic [4:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_INC, ALU_DEC, ALU_ASL, ALU_LSR, ALU_ROL, ALU_ROR
    } alu_op_e;

    typedef struct packed {
        logic [1:0]  size;
        addr_mode_e  mode;
        instr_type_e itype;
        reg_dest_e   dest;
        alu_op_e     alu_op;
        logic        use_alu;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } dec_info_t;

    localparam int DEC_INFO_W = $bits(dec_info_t);

    function automatic logic [1:0] mode_size(addr_mode_e m);
        case (m)
            AM_IMPL:          return 2'd1;
            AM_ABS, AM_ABSX:  return 2'd3;
            default:          return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/decode_queue_opcode_decode.sv
// Purely combinational opcode -> decoded-bundle lookup for the supported 6502 subset.
module opcode_decode
    import decode_queue_pkg::*;
#(
    parameter bit TRAP_ILL = 1'b1
) (
    input  logic [7:0]            opcode,
    output logic [DEC_INFO_W-1:0] info
);

    dec_info_t   d;
    instr_type_e t;
    addr_mode_e  m;
    logic        legal;
    logic        rmw;
    logic        store;

    always_comb begin
        t = I_LDA;
        m = AM_IMPL;
        legal = 1'b1;
        case (opcode)
            8'hA9: begin t = I_LDA; m = AM_IMM;  end
            8'hA5: begin t = I_LDA; m = AM_ZP;   end
            8'hAD: begin t = I_LDA; m = AM_ABS;  end
            8'hB5: begin t = I_LDA; m = AM_ZPX;  end
            8'hBD: begin t = I_LDA; m = AM_ABSX; end
            8'hA2: begin t = I_LDX; m = AM_IMM;  end
            8'hA6: begin t = I_LDX; m = AM_ZP;   end
            8'hAE: begin t = I_LDX; m = AM_ABS;  end
            8'hA0: begin t = I_LDY; m = AM_IMM;  end
            8'hA4: begin t = I_LDY; m = AM_ZP;   end
            8'hAC: begin t = I_LDY; m = AM_ABS;  end
            8'h85: begin t = I_STA; m = AM_ZP;   end
            8'h8D: begin t = I_STA; m = AM_ABS;  end
            8'h95: begin t = I_STA; m = AM_ZPX;  end
            8'h9D: begin t = I_STA; m = AM_ABSX; end
            8'h86: begin t = I_STX; m = AM_ZP;   end
            8'h8E: begin t = I_STX; m = AM_ABS;  end
            8'h84: begin t = I_STY; m = AM_ZP;   end
            8'h8C: begin t = I_STY; m = AM_ABS;  end
            8'h69: begin t = I_ADC; m = AM_IMM;  end
            8'h65: begin t = I_ADC; m = AM_ZP;   end
            8'h6D: begin t = I_ADC; m = AM_ABS;  end
            8'h75: begin t = I_ADC; m = AM_ZPX;  end
            8'h7D: begin t = I_ADC; m = AM_ABSX; end
            8'hE9: begin t = I_SBC; m = AM_IMM;  end
            8'hE5: begin t = I_SBC; m = AM_ZP;   end
            8'hED: begin t = I_SBC; m = AM_ABS;  end
            8'h29: begin t = I_AND; m = AM_IMM;  end
            8'h25: begin t = I_AND; m = AM_ZP;   end
            8'h2D: begin t = I_AND; m = AM_ABS;  end
            8'h09: begin t = I_ORA; m = AM_IMM;  end
            8'h05: begin t = I_ORA; m = AM_ZP;   end
            8'h0D: begin t = I_ORA; m = AM_ABS;  end
            8'h49: begin t = I_EOR; m = AM_IMM;  end
            8'h45: begin t = I_EOR; m = AM_ZP;   end
            8'h4D: begin t = I_EOR; m = AM_ABS;  end
            8'hE6: begin t = I_INC; m = AM_ZP;   end
            8'hEE: begin t = I_INC; m = AM_ABS;  end
            8'hC6: begin t = I_DEC; m = AM_ZP;   end
            8'hCE: begin t = I_DEC; m = AM_ABS;  end
            8'h0A: begin t = I_ASL; m = AM_IMPL; end
            8'h06: begin t = I_ASL; m = AM_ZP;   end
            8'h4A: begin t = I_LSR; m = AM_IMPL; end
            8'h46: begin t = I_LSR; m = AM_ZP;   end
            8'h2A: begin t = I_ROL; m = AM_IMPL; end
            8'h26: begin t = I_ROL; m = AM_ZP;   end
            8'h6A: begin t = I_ROR; m = AM_IMPL; end
            8'h66: begin t = I_ROR; m = AM_ZP;   end
            8'h10, 8'h30, 8'h50, 8'h70,
            8'h90, 8'hB0, 8'hD0, 8'hF0: begin t = I_BR; m = AM_REL; end
            8'h4C: begin t = I_JMP; m = AM_ABS;  end
            8'hE8: t = I_INX;
            8'hC8: t = I_INY;
            8'hCA: t = I_DEX;
            8'h88: t = I_DEY;
            8'hAA: t = I_TAX;
            8'h8A: t = I_TXA;
            8'hA8: t = I_TAY;
            8'h98: t = I_TYA;
            8'hBA: t = I_TSX;
            8'h9A: t = I_TXS;
            8'hEA: t = I_NOP;
            default: legal = 1'b0;
        endcase

        rmw   = t inside {I_INC, I_DEC, I_ASL, I_LSR, I_ROL, I_ROR};
        store = t inside {I_STA, I_STX, I_STY};

        d        = '0;
        d.itype  = t;
        d.mode   = m;
        d.size   = mode_size(m);
        case (t)
            I_LDA, I_ADC, I_SBC, I_AND, I_ORA, I_EOR, I_TXA, I_TYA: d.dest = RD_A;
            I_LDX, I_TAX, I_TSX, I_INX, I_DEX:                      d.dest = RD_X;
            I_LDY, I_TAY, I_INY, I_DEY:                             d.dest = RD_Y;
            I_STA, I_STX, I_STY, I_INC, I_DEC:                      d.dest = RD_MEM;
            I_ASL, I_LSR, I_ROL, I_ROR: d.dest = (m == AM_IMPL) ? RD_A : RD_MEM;
            I_TXS:                                                  d.dest = RD_SP;
            default:                                                d.dest = RD_NONE;
        endcase
        case (t)
            I_ADC:               d.alu_op = ALU_ADD;
            I_SBC:               d.alu_op = ALU_SUB;
            I_AND:               d.alu_op = ALU_AND;
            I_ORA:               d.alu_op = ALU_OR;
            I_EOR:               d.alu_op = ALU_XOR;
            I_INC, I_INX, I_INY: d.alu_op = ALU_INC;
            I_DEC, I_DEX, I_DEY: d.alu_op = ALU_DEC;
            I_ASL:               d.alu_op = ALU_ASL;
            I_LSR:               d.alu_op = ALU_LSR;
            I_ROL:               d.alu_op = ALU_ROL;
            I_ROR:               d.alu_op = ALU_ROR;
            default:             d.alu_op = ALU_NOP;
        endcase
        d.use_alu   = (d.alu_op != ALU_NOP);
        // JMP's operand is a target address, not a data fetch
        d.mem_read  = (m inside {AM_ZP, AM_ABS, AM_ZPX, AM_ABSX}) && !store && (t != I_JMP);
        d.mem_write = store || (rmw && (m != AM_IMPL));

        if (!legal) begin
            d         = '0;
            d.size    = 2'd1;
            d.illegal = TRAP_ILL;
        end
    end

    assign info = d;

endmodule

// File: rtl/decode_queue.sv
// Byte-serial 6502 instruction assembler feeding a circular queue of decoded bundles.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PC_W     = 16,
    parameter bit TRAP_ILL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [PC_W-1:0] dec_pc,
    output logic [7:0]      dec_opcode,
    output logic [15:0]     dec_operand,
    output logic [1:0]      dec_size,
    output logic [2:0]      dec_addr_mode,
    output logic [7:0]      dec_instr_type,
    output logic [2:0]      dec_reg_dest,
    output logic [4:0]      dec_alu_op,
    output logic            dec_use_alu,
    output logic            dec_mem_read,
    output logic            dec_mem_write,
    output logic            dec_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = DEPTH[PW:0];

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, op_pc_q, op_pc_d;
    logic [7:0]      op_q, op_d, lo_q, lo_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]     count_q, count_d;

    logic [PC_W-1:0] q_pc_q      [DEPTH];
    logic [PC_W-1:0] q_pc_d      [DEPTH];
    logic [7:0]      q_op_q      [DEPTH];
    logic [7:0]      q_op_d      [DEPTH];
    logic [15:0]     q_operand_q [DEPTH];
    logic [15:0]     q_operand_d [DEPTH];
    dec_info_t       q_info_q    [DEPTH];
    dec_info_t       q_info_d    [DEPTH];

    logic [DEC_INFO_W-1:0] cur_raw;
    dec_info_t             cur_info;
    dec_info_t             head;
    logic [7:0]            dec_in;
    logic                  accept, pop, push;
    logic [15:0]           push_operand;

    // Once past the opcode byte, decode from the latched opcode so size stays valid
    assign dec_in = (state_q == S_OP) ? byte_data : op_q;

    opcode_decode #(.TRAP_ILL(TRAP_ILL)) u_opcode_decode (
        .opcode (dec_in),
        .info   (cur_raw)
    );
    assign cur_info = cur_raw;

    assign byte_ready = !rst && !flush && (count_q != FULL);
    assign accept     = byte_valid && byte_ready;
    assign dec_valid  = (count_q != '0);
    assign pop        = dec_valid && dec_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        op_pc_d      = op_pc_q;
        op_d         = op_q;
        lo_d         = lo_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        q_pc_d       = q_pc_q;
        q_op_d       = q_op_q;
        q_operand_d  = q_operand_q;
        q_info_d     = q_info_q;
        push         = 1'b0;
        push_operand = '0;

        if (accept) begin
            pc_d = pc_q + 1'b1;
            case (state_q)
                S_OP: begin
                    op_d    = byte_data;
                    op_pc_d = pc_q;
                    lo_d    = '0;
                    if (cur_info.size == 2'd1) push = 1'b1;
                    else                       state_d = S_LO;
                end
                S_LO: begin
                    lo_d = byte_data;
                    if (cur_info.size == 2'd2) begin
                        push         = 1'b1;
                        push_operand = {8'h00, byte_data};
                        state_d      = S_OP;
                    end else begin
                        state_d = S_HI;
                    end
                end
                S_HI: begin
                    push         = 1'b1;
                    push_operand = {byte_data, lo_q};
                    state_d      = S_OP;
                end
                default: state_d = S_OP;
            endcase
        end

        if (push) begin
            q_pc_d[wr_ptr_q]      = (state_q == S_OP) ? pc_q : op_pc_q;
            q_op_d[wr_ptr_q]      = dec_in;
            q_operand_d[wr_ptr_q] = push_operand;
            q_info_d[wr_ptr_q]    = cur_info;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

        // Flush wins outright: drops the partial instruction and anything queued
        if (flush) begin
            state_d  = S_OP;
            pc_d     = flush_pc;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OP;
            pc_q     <= '0;
            op_pc_q  <= '0;
            op_q     <= '0;
            lo_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_q[i]      <= '0;
                q_op_q[i]      <= '0;
                q_operand_q[i] <= '0;
                q_info_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            op_pc_q     <= op_pc_d;
            op_q        <= op_d;
            lo_q        <= lo_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            q_pc_q      <= q_pc_d;
            q_op_q      <= q_op_d;
            q_operand_q <= q_operand_d;
            q_info_q    <= q_info_d;
        end
    end

    assign head           = q_info_q[rd_ptr_q];
    assign dec_pc         = q_pc_q[rd_ptr_q];
    assign dec_opcode     = q_op_q[rd_ptr_q];
    assign dec_operand    = q_operand_q[rd_ptr_q];
    assign dec_size       = head.size;
    assign dec_addr_mode  = head.mode;
    assign dec_instr_type = head.itype;
    assign dec_reg_dest   = head.dest;
    assign dec_alu_op     = head.alu_op;
    assign dec_use_alu    = head.use_alu;
    assign dec_mem_read   = head.mem_read;
    assign dec_mem_write  = head.mem_write;
    assign dec_illegal    = head.illegal;

endmodule
